// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencing (stall/flush/mem-wait) controller.
// Ports: clk/reset, hazard reqs, imem/dmem ready -> stage write/flush, perf ctrs.
module pipe_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             do_flush,
  input  logic             imem_ready,
  input  logic             MEM_mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LD = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  state_t        state, state_nxt;
  logic [BW-1:0] boot_cnt, boot_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          kill_fetch, kill_nxt;
  logic          flush_acc;
  logic          dmem_wait;

  assign dmem_wait = MEM_mem_access & ~dmem_ready;

  always_comb begin
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_write  = 1'b0;
    EX_MEM_write = 1'b0;
    MEM_WB_write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    state_nxt    = state;
    boot_nxt     = boot_cnt;
    kill_nxt     = kill_fetch;
    flush_acc    = 1'b0;
    if (state == HOLD) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      MEM_WB_flush = 1'b1;
      if (boot_cnt == '0) state_nxt = RUN;
      else boot_nxt = boot_cnt - 1'b1;
    end else begin
      state_nxt = RUN;
      if (dmem_wait) begin
        // Requests from hazard unit stay frozen; revisit them on ready.
        MEM_WB_flush = 1'b1;
        state_nxt    = MEM_WAIT;
      end else if (do_flush) begin
        pc_write     = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        flush_acc    = 1'b1;
        // Fetch in flight on the old path must be dropped when it lands.
        kill_nxt     = ~imem_ready;
      end else if (stall) begin
        ID_EX_flush  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
      end else if (kill_fetch || !imem_ready) begin
        IF_ID_flush  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        if (kill_fetch && imem_ready) kill_nxt = 1'b0;
      end else begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
      end
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (state == MEM_WAIT)
      wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      boot_cnt   <= BOOT_LD;
      kill_fetch <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      boot_cnt   <= boot_nxt;
      kill_fetch <= kill_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (state == MEM_WAIT && wait_nxt >= WAIT_MAX)
        mem_timeout <= 1'b1;
      if (state != HOLD && !pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_acc && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl.
// Small CNT_W/MEM_TIMEOUT so saturation and timeout are reachable.
module tb_pipe_ctrl;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  logic stall, do_flush, imem_ready, MEM_mem_access, dmem_ready;
  logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .BOOT_CYCLES(2),
    .MEM_TIMEOUT(3),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .do_flush(do_flush),
    .imem_ready(imem_ready),
    .MEM_mem_access(MEM_mem_access),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write),
    .IF_ID_write(IF_ID_write),
    .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write),
    .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush),
    .MEM_WB_flush(MEM_WB_flush),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  // {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f}
  logic [8:0] ctl;
  assign ctl = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                MEM_WB_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
                MEM_WB_flush};

  localparam logic [8:0] C_HOLD  = 9'b00000_1111;
  localparam logic [8:0] C_RUN   = 9'b11111_0000;
  localparam logic [8:0] C_STALL = 9'b00011_0100;
  localparam logic [8:0] C_FLUSH = 9'b10011_1100;
  localparam logic [8:0] C_IFBUB = 9'b00111_1000;
  localparam logic [8:0] C_DWAIT = 9'b00000_0001;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic ir,
                       input logic ma, input logic dr);
    stall = s;
    do_flush = f;
    imem_ready = ir;
    MEM_mem_access = ma;
    dmem_ready = dr;
    #2;
  endtask

  task automatic boot;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("boot_hold0", 32'(ctl), 32'(C_HOLD));
    tick;
    #2;
    check("boot_hold1", 32'(ctl), 32'(C_HOLD));
    tick;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 1, 0, 0);
    check("rst_ctl", 32'(ctl), 32'(C_HOLD));
    check("rst_to", 32'(mem_timeout), 0);
    check("rst_sc", 32'(stall_cycles), 0);
    check("rst_fc", 32'(flush_count), 0);
    boot;

    drive(0, 0, 1, 0, 0);
    check("run_ctl", 32'(ctl), 32'(C_RUN));
    check("boot_sc", 32'(stall_cycles), 0);

    drive(1, 0, 1, 0, 0);
    check("stall_ctl", 32'(ctl), 32'(C_STALL));
    tick;
    drive(0, 0, 1, 0, 0);
    check("stall_sc", 32'(stall_cycles), 1);
    check("after_stall", 32'(ctl), 32'(C_RUN));

    drive(1, 1, 1, 0, 0);
    check("flush_stall", 32'(ctl), 32'(C_FLUSH));
    tick;
    drive(0, 0, 1, 0, 0);
    check("flush_fc", 32'(flush_count), 1);
    check("flush_sc", 32'(stall_cycles), 1);
    check("flush_nokill", 32'(ctl), 32'(C_RUN));

    drive(0, 1, 0, 0, 0);
    check("flush_nr", 32'(ctl), 32'(C_FLUSH));
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, (i == 2), 0, 0);
      check($sformatf("kill%0d", i), 32'(ctl), 32'(C_IFBUB));
      tick;
    end
    drive(0, 0, 1, 0, 0);
    check("kill_done", 32'(ctl), 32'(C_RUN));
    check("kill_fc", 32'(flush_count), 2);
    check("kill_sc", 32'(stall_cycles), 4);

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1, 0);
      check($sformatf("dwait%0d", i), 32'(ctl), 32'(C_DWAIT));
      tick;
      if (i == 1) check("dwait_sc6", 32'(stall_cycles), 6);
      if (i == 2) check("to_early", 32'(mem_timeout), 0);
    end
    check("to_set", 32'(mem_timeout), 1);
    check("sc_sat", 32'(stall_cycles), 7);
    check("dwait_fc", 32'(flush_count), 2);
    drive(0, 1, 1, 1, 1);
    check("dready_flush", 32'(ctl), 32'(C_FLUSH));
    tick;
    drive(0, 0, 1, 0, 0);
    check("dready_fc", 32'(flush_count), 3);
    check("to_sticky", 32'(mem_timeout), 1);
    check("post_wait", 32'(ctl), 32'(C_RUN));
    tick;
    check("to_sticky2", 32'(mem_timeout), 1);

    drive(0, 1, 0, 0, 0);
    tick;
    drive(0, 0, 1, 0, 0);
    check("kill_pre_rst", 32'(ctl), 32'(C_IFBUB));
    reset = 1'b1;
    #1;
    check("rst2_ctl", 32'(ctl), 32'(C_HOLD));
    check("rst2_to", 32'(mem_timeout), 0);
    check("rst2_fc", 32'(flush_count), 0);
    check("rst2_sc", 32'(stall_cycles), 0);
    boot;
    drive(0, 0, 1, 0, 0);
    check("rst2_nokill", 32'(ctl), 32'(C_RUN));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage core. Combines the load-use stall and flush requests from the hazard unit with the instruction- and data-memory ready handshakes, and produces the per-stage write enables and bubble inserts for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It holds the pipe idle for a fixed boot interval after reset, tracks a stale fetch after a redirect, and keeps saturating stall/flush performance counters plus a sticky data-memory timeout flag.

## Interface
- BOOT_CYCLES, 2: cycles in HOLD after reset release (>=1).
- MEM_TIMEOUT, 255: consecutive MEM_WAIT cycles that set mem_timeout.
- CNT_W, 32: performance counter width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  load-use stall request from the hazard unit.
- do_flush  in  1  redirect request: branch taken or jump.
- imem_ready  in  1  IF instruction valid; held by imem until consumed.
- MEM_mem_access  in  1  load or store present in MEM.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- pc_write  out  1  PC loads next/target.
- IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  out  1 each  stage register load enable.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load a bubble. Flush dominates write, and the register clears even when its write is 0.
- mem_timeout  out  1  sticky; set when a data access waits MEM_TIMEOUT cycles.
- stall_cycles  out  CNT_W  cycles with pc_write=0 outside HOLD; saturating.
- flush_count  out  CNT_W  accepted redirects; saturating.

## Operation
- State register: HOLD, RUN, MEM_WAIT. Separate flag kill_fetch.
- HOLD:
  - All *_write=0 and all *_flush=1.
  - The boot counter loads BOOT_CYCLES-1 on reset and decrements each cycle. Go to RUN when it reaches 0.
- Outputs are combinational on state, kill_fetch and inputs. In RUN and MEM_WAIT, evaluate by priority, first match wins:
  - Rule 1, dmem_wait = MEM_mem_access & !dmem_ready:
    - pc_write, IF_ID_write, ID_EX_write and EX_MEM_write are 0. MEM_WB_flush=1.
    - stall and do_flush are ignored; sources stay frozen and hold their requests.
    - Next state is MEM_WAIT.
  - Rule 2, do_flush:
    - pc_write=1, IF_ID_flush=1, ID_EX_flush=1. EX_MEM_write=1, MEM_WB_write=1.
    - flush_count increments.
    - kill_fetch is set if imem_ready=0, cleared otherwise.
  - Rule 3, stall:
    - pc_write=0, IF_ID_write=0, ID_EX_flush=1. EX_MEM and MEM_WB advance.
  - Rule 4, kill_fetch=1:
    - pc_write=0, IF_ID_flush=1. Others advance.
    - If imem_ready=1, clear kill_fetch (the stale word is discarded).
  - Rule 5, !imem_ready:
    - pc_write=0, IF_ID_flush=1. Others advance.
  - Otherwise: all *_write=1, no flush.
- Any cycle not matching rule 1 returns to RUN. Otherwise the state is MEM_WAIT.
- Wait counter:
  - Clears whenever the state is not MEM_WAIT.
  - Increments each MEM_WAIT cycle and saturates.
  - mem_timeout sets when the counter reaches MEM_TIMEOUT. It clears only on reset.
- stall_cycles increments on every non-HOLD cycle with pc_write=0.

## Timing
- Reset (asynchronous) puts the block in HOLD with counters at 0, mem_timeout=0 and kill_fetch=0.
- Output values during reset:
  - pc_write=0 and every *_write=0.
  - Every *_flush=1.
  - mem_timeout=0, stall_cycles=0, flush_count=0.
- First possible pc_write=1 is BOOT_CYCLES cycles after reset deasserts.
- Control outputs have zero latency: they are valid in the same cycle as their inputs. Counters and flags are visible the cycle after the event.
- A redirect during a data wait is applied on the first cycle with dmem_ready=1. Rule 1 no longer matches, so rule 2 takes effect that cycle.
- Reset mid-MEM_WAIT or with kill_fetch set abandons the wait and clears the flag.
- Counters saturate at all-ones. They do not wrap.

## Test plan
- Reset with BOOT_CYCLES=2, then imem_ready=1 and other inputs 0.
  - Two cycles of all-flush and pc_write=0, then all *_write=1.
  - stall_cycles stays 0.
- stall=1 for one cycle in RUN.
  - pc_write=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM_write=1.
  - stall_cycles becomes 1 on the next cycle.
- do_flush=1 together with stall=1.
  - pc_write=1, IF_ID_flush=1, ID_EX_flush=1, flush_count becomes 1.
- do_flush=1 while imem_ready=0, then imem_ready=1 three cycles later.
  - kill_fetch is set, and IF_ID_flush=1 and pc_write=0 through the ready cycle.
  - On the next cycle with imem_ready=1, pc_write=1 and IF_ID_write=1.
- MEM_mem_access=1 with dmem_ready=0 for 4 cycles and do_flush=1 throughout.
  - Front stages frozen and MEM_WB_flush=1; no flush is accepted.
  - On the ready cycle, the redirect is applied and flush_count increments by 1.
- MEM_TIMEOUT=3 with dmem_ready held 0.
  - mem_timeout rises after the 3rd MEM_WAIT cycle.
  - It stays 1 after dmem_ready=1 and clears only on reset.
